// File: rtl/pcie_link_sequencer_if.sv
// rtl/pcie_link_sequencer_if.sv - platform-side bundle between pcie_link_sequencer and the platform layer
//
// Signals:
//   enable      level; 0 parks the sequencer in ST_RESET
//   restart     single-cycle pulse; restarts bring-up from any state
//   pll_lock    endpoint PLL locked
//   link_up     endpoint data link layer up
//   core_rst_n  active-low reset to the endpoint core
//   clk_gate    user clock enable
//   link_ready  link usable
//   link_fail   bring-up exhausted its retries
//   retry_cnt   failed attempts in the current sequence
//   state       0 ST_RESET, 1 ST_LOCK, 2 ST_TRAIN, 3 ST_UP, 4 ST_FAIL
// Modports: master = sequencer side, slave = platform/endpoint side.

interface pcie_link_sequencer_if #(
    parameter int RETRY_W = 4
);
    logic               enable;
    logic               restart;
    logic               pll_lock;
    logic               link_up;
    logic               core_rst_n;
    logic               clk_gate;
    logic               link_ready;
    logic               link_fail;
    logic [RETRY_W-1:0] retry_cnt;
    logic [2:0]         state;

    modport master (
        input  enable, restart, pll_lock, link_up,
        output core_rst_n, clk_gate, link_ready, link_fail, retry_cnt, state
    );

    modport slave (
        output enable, restart, pll_lock, link_up,
        input  core_rst_n, clk_gate, link_ready, link_fail, retry_cnt, state
    );
endinterface

// File: rtl/pcie_link_sequencer.sv
// rtl/pcie_link_sequencer.sv - PCIe endpoint bring-up/recovery sequencer with bounded retries
//
// Ports:
//   CLK  sole clock
//   RST  synchronous active-high reset
//   sq   pcie_link_sequencer_if.master (enable/restart/pll_lock/link_up in;
//        core_rst_n/clk_gate/link_ready/link_fail/retry_cnt/state out)
// Every output is registered and derived from the state being entered, so it
// changes on the same edge as the state.
// Optional feature macro: PCIE_LINKDOWN_DEBOUNCE_EN (link_up must stay low for
// DEBOUNCE_CYCLES consecutive cycles in ST_UP before the link counts as lost).

module pcie_link_sequencer #(
    parameter int RESET_CYCLES    = 64,
    parameter int LINK_TIMEOUT    = 1000000,
    parameter int MAX_RETRIES     = 3,
    parameter int RETRY_W         = 4,
    parameter int CNT_W           = 20,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    pcie_link_sequencer_if.master sq
);

    // Parameter sanity, evaluated at elaboration only.
    if (RESET_CYCLES < 1) begin : g_bad_reset_cycles
        $error("RESET_CYCLES must be at least 1");
    end
    if (LINK_TIMEOUT < 2) begin : g_bad_link_timeout
        $error("LINK_TIMEOUT must be at least 2");
    end
    if (longint'(MAX_RETRIES) >= (longint'(1) << RETRY_W)) begin : g_bad_retries
        $error("MAX_RETRIES does not fit in RETRY_W bits");
    end
    if ((longint'(LINK_TIMEOUT - 1) >= (longint'(1) << CNT_W)) ||
        (longint'(RESET_CYCLES - 1) >= (longint'(1) << CNT_W))) begin : g_bad_cnt_w
        $error("CNT_W too narrow for RESET_CYCLES/LINK_TIMEOUT");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {
        ST_RESET = 3'd0,
        ST_LOCK  = 3'd1,
        ST_TRAIN = 3'd2,
        ST_UP    = 3'd3,
        ST_FAIL  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0]   RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LINK_TIMEOUT - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               core_rst_n_q, core_rst_n_d;
    logic               clk_gate_q, clk_gate_d;
    logic               link_ready_q, link_ready_d;
    logic               link_fail_q, link_fail_d;
    logic               fail_attempt;

`ifdef PCIE_LINKDOWN_DEBOUNCE_EN
    localparam int             DEB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
    logic [DEB_W-1:0] deb_q, deb_d;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_RESET;
            cnt_q        <= '0;
            retry_q      <= '0;
            core_rst_n_q <= 1'b0;
            clk_gate_q   <= 1'b0;
            link_ready_q <= 1'b0;
            link_fail_q  <= 1'b0;
`ifdef PCIE_LINKDOWN_DEBOUNCE_EN
            deb_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            core_rst_n_q <= core_rst_n_d;
            clk_gate_q   <= clk_gate_d;
            link_ready_q <= link_ready_d;
            link_fail_q  <= link_fail_d;
`ifdef PCIE_LINKDOWN_DEBOUNCE_EN
            deb_q        <= deb_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        retry_d      = retry_q;
        fail_attempt = 1'b0;
`ifdef PCIE_LINKDOWN_DEBOUNCE_EN
        // Debounce count only survives while ST_UP keeps seeing link_up low.
        deb_d        = '0;
`endif

        if (sq.restart) begin
            state_d = ST_RESET;
            cnt_d   = '0;
            retry_d = '0;
        end else if (!sq.enable && (state_q != ST_FAIL)) begin
            state_d = ST_RESET;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            unique case (state_q)
                ST_RESET: begin
                    if (cnt_q == RESET_LAST) begin
                        state_d = ST_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_LOCK: begin
                    if (sq.pll_lock) begin
                        state_d = ST_TRAIN;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        fail_attempt = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_TRAIN: begin
                    // link_up is checked first so a link arriving on the
                    // timeout cycle is still accepted.
                    if (sq.link_up) begin
                        state_d = ST_UP;
                        cnt_d   = '0;
                    end else if (!sq.pll_lock) begin
                        // Lost lock is not the endpoint's fault: redo the
                        // attempt without consuming a retry.
                        state_d = ST_RESET;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        fail_attempt = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_UP: begin
                    if (!sq.pll_lock) begin
                        state_d = ST_RESET;
                        cnt_d   = '0;
                        retry_d = '0;
                    end else begin
`ifdef PCIE_LINKDOWN_DEBOUNCE_EN
                        if (!sq.link_up) begin
                            if (deb_q == DEB_LAST) begin
                                state_d = ST_RESET;
                                cnt_d   = '0;
                                retry_d = '0;
                            end else begin
                                deb_d = deb_q + DEB_W'(1);
                            end
                        end
`else
                        if (!sq.link_up) begin
                            state_d = ST_RESET;
                            cnt_d   = '0;
                            retry_d = '0;
                        end
`endif
                    end
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_RESET;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            endcase

            if (fail_attempt) begin
                cnt_d = '0;
                if (retry_q == RETRY_LIMIT) begin
                    state_d = ST_FAIL;
                end else begin
                    retry_d = retry_q + RETRY_W'(1);
                    state_d = ST_RESET;
                end
            end
        end

        // Outputs follow the state being entered so they land on the same edge.
        core_rst_n_d = (state_d == ST_TRAIN) || (state_d == ST_UP);
        clk_gate_d   = (state_d == ST_UP);
        link_ready_d = (state_d == ST_UP);
        link_fail_d  = (state_d == ST_FAIL);
    end

    assign sq.core_rst_n = core_rst_n_q;
    assign sq.clk_gate   = clk_gate_q;
    assign sq.link_ready = link_ready_q;
    assign sq.link_fail  = link_fail_q;
    assign sq.retry_cnt  = retry_q;
    assign sq.state      = state_q;

endmodule

// File: tb/tb_pcie_link_sequencer.sv
// tb/tb_pcie_link_sequencer.sv - self-checking bench for pcie_link_sequencer

module tb_pcie_link_sequencer;

    localparam int RC  = 4;
    localparam int LT  = 16;
    localparam int MR  = 2;
    localparam int RW  = 4;
    localparam int CW  = 8;
    localparam int DEB = 3;

`ifdef PCIE_LINKDOWN_DEBOUNCE_EN
    localparam int LOSS_LEN     = DEB;
    localparam int GLITCH_STATE = 3;
`else
    localparam int LOSS_LEN     = 1;
    localparam int GLITCH_STATE = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    // Reference model: state number, cycles spent in the current state,
    // failed attempts so far, consecutive low link_up cycles while up.
    int m_state = 0;
    int m_dwell = 0;
    int m_retry = 0;
    int m_low   = 0;

    int t1_exp[10] = '{0, 0, 0, 1, 2, 2, 2, 2, 2, 3};

    pcie_link_sequencer_if #(.RETRY_W(RW)) bus ();

    pcie_link_sequencer #(
        .RESET_CYCLES   (RC),
        .LINK_TIMEOUT   (LT),
        .MAX_RETRIES    (MR),
        .RETRY_W        (RW),
        .CNT_W          (CW),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .sq (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic enter(input int s);
        m_state = s;
        m_dwell = 0;
        m_low   = 0;
    endtask

    task automatic attempt_failed();
        if (m_retry == MR) begin
            enter(4);
        end else begin
            m_retry++;
            enter(0);
        end
    endtask

    task automatic model_step();
        bit rs = rst;
        bit rq = bus.restart;
        bit en = bus.enable;
        bit pl = bus.pll_lock;
        bit lu = bus.link_up;
        if (rs || rq || (!en && m_state != 4)) begin
            m_retry = 0;
            enter(0);
            return;
        end
        case (m_state)
            0: begin
                m_dwell++;
                if (m_dwell == RC) enter(1);
            end
            1: begin
                if (pl) enter(2);
                else begin
                    m_dwell++;
                    if (m_dwell == LT) attempt_failed();
                end
            end
            2: begin
                if (lu) enter(3);
                else if (!pl) enter(0);
                else begin
                    m_dwell++;
                    if (m_dwell == LT) attempt_failed();
                end
            end
            3: begin
                if (!pl) begin
                    m_retry = 0;
                    enter(0);
                end else if (lu) begin
                    m_low = 0;
                end else begin
                    m_low++;
                    if (m_low >= LOSS_LEN) begin
                        m_retry = 0;
                        enter(0);
                    end
                end
            end
            default: ;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("state", bus.state, m_state);
        check("retry_cnt", bus.retry_cnt, m_retry);
        check("core_rst_n", bus.core_rst_n, (m_state == 2 || m_state == 3));
        check("clk_gate", bus.clk_gate, m_state == 3);
        check("link_ready", bus.link_ready, m_state == 3);
        check("link_fail", bus.link_fail, m_state == 4);
    endtask

    task automatic pulse_restart();
        bus.restart = 1'b1;
        tick();
        bus.restart = 1'b0;
    endtask

    task automatic wait_for(input string tag, input int st, input int rt, input int limit);
        bit hit = 1'b0;
        for (int i = 0; i < limit && !hit; i++) begin
            tick();
            hit = (bus.state == st) && (bus.retry_cnt == rt);
        end
        check(tag, hit, 1);
    endtask

    initial begin
        int n_cyc;
        bit hit;
        bit rst_n_seen;

        rst = 1'b1;
        bus.enable   = 1'b0;
        bus.restart  = 1'b0;
        bus.pll_lock = 1'b0;
        bus.link_up  = 1'b0;
        tick();
        tick();
        check("rst_state", bus.state, 0);
        check("rst_core_rst_n", bus.core_rst_n, 0);
        check("rst_link_fail", bus.link_fail, 0);

        // 1: clean bring-up, link_up 5 cycles after core_rst_n rises
        rst = 1'b0;
        bus.enable   = 1'b1;
        bus.pll_lock = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 9) bus.link_up = 1'b1;
            tick();
            check("t1_seq", bus.state, t1_exp[i]);
        end
        check("t1_link_ready", bus.link_ready, 1);
        check("t1_clk_gate", bus.clk_gate, 1);

        // 2: training never succeeds -> three 16-cycle training periods then fail
        bus.link_up = 1'b0;
        pulse_restart();
        n_cyc = 0;
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            tick();
            if (bus.state == 2) n_cyc++;
            hit = (bus.state == 4);
        end
        check("t2_reached_fail", hit, 1);
        check("t2_train_cycles", n_cyc, 3 * LT);
        check("t2_retry", bus.retry_cnt, MR);
        check("t2_link_fail", bus.link_fail, 1);
        check("t2_core_rst_n", bus.core_rst_n, 0);
        bus.enable = 1'b0;
        tick();
        check("t2_fail_ignores_enable", bus.state, 4);
        bus.enable = 1'b1;
        pulse_restart();
        check("t2_restart_state", bus.state, 0);
        check("t2_restart_retry", bus.retry_cnt, 0);
        check("t2_restart_fail", bus.link_fail, 0);

        // 3: single-cycle link_up glitch in ST_UP
        bus.link_up = 1'b1;
        wait_for("t3_up", 3, 0, 50);
        bus.link_up = 1'b0;
        tick();
        bus.link_up = 1'b1;
        check("t3_glitch", bus.state, GLITCH_STATE);
`ifdef PCIE_LINKDOWN_DEBOUNCE_EN
        tick();
        bus.link_up = 1'b0;
        tick();
        check("t3_low1", bus.state, 3);
        tick();
        check("t3_low2", bus.state, 3);
        tick();
        check("t3_low3", bus.state, 0);
        bus.link_up = 1'b1;
`endif

        // 4: PLL never locks -> 16 cycles in ST_LOCK per attempt, 3 attempts
        bus.link_up  = 1'b0;
        bus.pll_lock = 1'b0;
        pulse_restart();
        n_cyc = 0;
        hit = 1'b0;
        rst_n_seen = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            tick();
            if (bus.state == 1) n_cyc++;
            if (bus.core_rst_n !== 1'b0) rst_n_seen = 1'b1;
            hit = (bus.state == 4);
        end
        check("t4_reached_fail", hit, 1);
        check("t4_lock_cycles", n_cyc, 3 * LT);
        check("t4_core_rst_n_stayed_low", rst_n_seen, 0);

        // 5: enable drop in ST_TRAIN with retry_cnt=1, then RST in ST_UP
        bus.pll_lock = 1'b1;
        pulse_restart();
        wait_for("t5_train_r1", 2, 1, 100);
        bus.enable = 1'b0;
        tick();
        check("t5_dis_state", bus.state, 0);
        check("t5_dis_retry", bus.retry_cnt, 0);
        for (int i = 0; i < 3; i++) tick();
        bus.enable = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("t5_reset_dwell", bus.state, 0);
        tick();
        check("t5_lock_after_dwell", bus.state, 1);
        bus.link_up = 1'b1;
        wait_for("t5_up", 3, 0, 20);
        rst = 1'b1;
        tick();
        check("t5_rst_state", bus.state, 0);
        check("t5_rst_core_rst_n", bus.core_rst_n, 0);
        check("t5_rst_clk_gate", bus.clk_gate, 0);
        check("t5_rst_link_ready", bus.link_ready, 0);
        rst = 1'b0;

        // 6: link_up on the timeout cycle wins; restart with enable=0
        bus.link_up = 1'b0;
        pulse_restart();
        wait_for("t6_train_r1", 2, 1, 100);
        for (int i = 0; i < LT - 1; i++) tick();
        bus.link_up = 1'b1;
        tick();
        check("t6_link_wins", bus.state, 3);
        check("t6_retry_kept", bus.retry_cnt, 1);
        bus.restart = 1'b1;
        bus.enable  = 1'b0;
        tick();
        check("t6_restart_dis_state", bus.state, 0);
        check("t6_restart_dis_retry", bus.retry_cnt, 0);
        bus.restart = 1'b0;
        bus.enable  = 1'b1;

        // Randomized soak against the reference model
        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(0, 999) < 3);
            bus.restart  = ($urandom_range(0, 999) < 5);
            bus.enable   = ($urandom_range(0, 99) < 97);
            if ($urandom_range(0, 99) < 4)  bus.pll_lock = ~bus.pll_lock;
            if ($urandom_range(0, 99) < 10) bus.link_up  = ~bus.link_up;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
